traffic_cmd_parser: RTL and testbench

- Upstream command front-end for traffic_lights. It receives a byte stream from the host link (UART receiver or debug bridge) and assembles 3-byte frames.
- It validates each frame and emits single-cycle commands on the cmd_type/cmd_valid/cmd_data interface that traffic_lights consumes.
- Malformed, incomplete and stalled frames are dropped. Each drop is flagged with an error code and never reaches the light controller.

---
 rtl/traffic_cmd_pkg.sv | 36 +++
 rtl/sat_counter.sv | 19 +
 rtl/traffic_cmd_parser.sv | 148 ++++++++++++++
 tb/tb_traffic_cmd_parser.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_cmd_pkg.sv
// Shared command/error encodings for the traffic command parser
// and the traffic_lights controller it feeds.
package traffic_cmd_pkg;

  localparam int FRAME_LEN = 3;

  typedef enum logic [2:0] {
    TURN_ON         = 3'd0,
    TURN_OFF        = 3'd1,
    SET_UNCONTR     = 3'd2,
    SET_GREEN_TIME  = 3'd3,
    SET_RED_TIME    = 3'd4,
    SET_YELLOW_TIME = 3'd5
  } cmd_type_t;

  typedef enum logic [1:0] {
    BAD_SYNC  = 2'd0,
    BAD_TYPE  = 2'd1,
    TIMEOUT   = 2'd2,
    ZERO_TIME = 2'd3
  } err_code_t;

  function automatic logic type_legal(
    input logic [2:0] t
  );
    return t <= 3'(SET_YELLOW_TIME);
  endfunction

  function automatic logic is_time_cmd(
    input logic [2:0] t
  );
    return t >= 3'(SET_GREEN_TIME) &&
           t <= 3'(SET_YELLOW_TIME);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (inc && q != '1) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_cmd_parser.sv
// Assembles 3-byte host frames into single-cycle
// traffic_lights commands; bad or stalled frames are dropped.
module traffic_cmd_parser
  import traffic_cmd_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter logic [3:0] SYNC_NIBBLE    = 4'hA,
  parameter int         CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [7:0]       byte_data_i,
  input  logic             byte_valid_i,
  output logic [2:0]       cmd_type_o,
  output logic [15:0]      cmd_data_o,
  output logic             cmd_valid_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] cmd_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    HDR_OK,
    DATA_HI
  } state_t;

  localparam int IW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] TO_LAST =
    IW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [IW-1:0] idle_cnt;
  logic [2:0]    typ;
  logic [7:0]    data_hi;

  logic        hdr_sync;
  logic        bad_sync;
  logic        bad_type;
  logic        hdr_good;
  logic [15:0] word;

  assign hdr_sync = byte_data_i[7:4] == SYNC_NIBBLE &&
                    !byte_data_i[3];
  assign bad_sync = !hdr_sync;
  assign bad_type = hdr_sync &&
                    !type_legal(byte_data_i[2:0]);
  assign hdr_good = hdr_sync &&
                    type_legal(byte_data_i[2:0]);
  assign word     = {data_hi, byte_data_i};

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      state       <= IDLE;
      idle_cnt    <= '0;
      typ         <= '0;
      data_hi     <= '0;
      cmd_valid_o <= 1'b0;
      cmd_type_o  <= '0;
      cmd_data_o  <= '0;
      err_o       <= 1'b0;
      err_code_o  <= '0;
      busy_o      <= 1'b0;
    end else begin
      cmd_valid_o <= 1'b0;
      cmd_type_o  <= '0;
      cmd_data_o  <= '0;
      err_o       <= 1'b0;
      err_code_o  <= '0;
      unique case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (byte_valid_i) begin
            unique case (1'b1)
              bad_sync: begin
                err_o      <= 1'b1;
                err_code_o <= BAD_SYNC;
              end
              bad_type: begin
                err_o      <= 1'b1;
                err_code_o <= BAD_TYPE;
              end
              hdr_good: begin
                typ    <= byte_data_i[2:0];
                state  <= HDR_OK;
                busy_o <= 1'b1;
              end
            endcase
          end
        end
        HDR_OK, DATA_HI: begin
          if (byte_valid_i) begin
            idle_cnt <= '0;
            if (state == HDR_OK) begin
              data_hi <= byte_data_i;
              state   <= DATA_HI;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
              // time settings of zero would stall the lights
              if (is_time_cmd(typ) && word == '0) begin
                err_o      <= 1'b1;
                err_code_o <= ZERO_TIME;
              end else begin
                cmd_valid_o <= 1'b1;
                cmd_type_o  <= typ;
                cmd_data_o  <= word;
              end
            end
          end else if (idle_cnt == TO_LAST) begin
            idle_cnt   <= '0;
            state      <= IDLE;
            busy_o     <= 1'b0;
            err_o      <= 1'b1;
            err_code_o <= TIMEOUT;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cmd_cnt (
    .clk  (clk_i),
    .clear(!srst_i),
    .inc  (cmd_valid_o),
    .q    (cmd_cnt_o)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk  (clk_i),
    .clear(!srst_i),
    .inc  (err_o),
    .q    (err_cnt_o)
  );

endmodule

// File: tb/tb_traffic_cmd_parser.sv
// Directed bench for traffic_cmd_parser with an
// event scoreboard keyed on the expected clock edge.
module tb_traffic_cmd_parser;

  logic        clk_i = 1'b0;
  logic        srst_i;
  logic [7:0]  byte_data_i;
  logic        byte_valid_i;
  logic [2:0]  cmd_type_o;
  logic [15:0] cmd_data_o;
  logic        cmd_valid_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic        busy_o;
  logic [15:0] cmd_cnt_o;
  logic [15:0] err_cnt_o;

  traffic_cmd_parser #(
    .TIMEOUT_CYCLES(8),
    .SYNC_NIBBLE   (4'hA),
    .CNT_W         (16)
  ) dut (
    .clk_i       (clk_i),
    .srst_i      (srst_i),
    .byte_data_i (byte_data_i),
    .byte_valid_i(byte_valid_i),
    .cmd_type_o  (cmd_type_o),
    .cmd_data_o  (cmd_data_o),
    .cmd_valid_o (cmd_valid_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o),
    .busy_o      (busy_o),
    .cmd_cnt_o   (cmd_cnt_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        is_err;
    logic [2:0]  t;
    logic [15:0] d;
    logic [1:0]  c;
    int          at;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  edge_n = 0;
  bit  mon_en = 0;

  ev_t         e;
  logic [53:0] o_v;
  logic [53:0] e_v;

  always @(posedge clk_i) edge_n++;

  always @(negedge clk_i) begin
    if (mon_en) begin
      if (cmd_valid_o || err_o) begin
        checks++;
        assert (!(cmd_valid_o && err_o)) else begin
          errors++;
          $error("FAIL both_strobes cmd=%0b err=%0b",
                 cmd_valid_o, err_o);
        end
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_evt edge=%0d err=%0b code=%0d type=%0d data=%h",
                 edge_n, err_o, err_code_o,
                 cmd_type_o, cmd_data_o);
        end
        if (sb.size() != 0) begin
          e   = sb.pop_front();
          o_v = {err_o, cmd_type_o, cmd_data_o,
                 err_code_o, 32'(edge_n)};
          e_v = {e.is_err, e.t, e.d, e.c, 32'(e.at)};
          checks++;
          assert (o_v === e_v) else begin
            errors++;
            $error("FAIL event got=%h exp=%h", o_v, e_v);
          end
        end
      end else begin
        checks++;
        assert ({cmd_type_o, cmd_data_o, err_code_o}
                === 21'd0) else begin
          errors++;
          $error("FAIL idle_zero got type=%0d data=%h code=%0d exp 0",
                 cmd_type_o, cmd_data_o, err_code_o);
        end
        if (sb.size() != 0) begin
          checks++;
          assert (sb[0].at > edge_n) else begin
            errors++;
            $error("FAIL missing_evt edge=%0d exp_at=%0d err=%0b",
                   edge_n, sb[0].at, sb[0].is_err);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic check(input string name,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", name, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    byte_data_i  = b;
    byte_valid_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic exp_cmd(input logic [2:0] t,
                         input logic [15:0] d,
                         input int off);
    sb.push_back('{1'b0, t, d, 2'd0, edge_n + off});
  endtask

  task automatic exp_err(input logic [1:0] c,
                         input int off);
    sb.push_back('{1'b1, 3'd0, 16'd0, c, edge_n + off});
  endtask

  initial begin
    srst_i       = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    repeat (2) @(negedge clk_i);
    check("reset_outs",
          {cmd_valid_o, err_o, busy_o, cmd_type_o,
           cmd_data_o, err_code_o},
          64'd0);
    check("reset_cnts", {cmd_cnt_o, err_cnt_o}, 64'd0);
    srst_i = 1'b1;
    mon_en = 1'b1;
    idle(1);

    send(8'hA3); send(8'h00);
    exp_cmd(3'd3, 16'h000A, 1); send(8'h0A);
    send(8'hA5); send(8'h00);
    exp_cmd(3'd5, 16'h000A, 1); send(8'h0A);
    send(8'hA0); send(8'h00);
    exp_cmd(3'd0, 16'h0000, 1); send(8'h00);
    idle(2);
    check("cmd_cnt_3", 64'(cmd_cnt_o), 64'd3);

    exp_err(2'd0, 1); send(8'h5A);
    send(8'hA4); send(8'h00);
    exp_cmd(3'd4, 16'h0007, 1); send(8'h07);
    idle(2);
    check("err_cnt_1", 64'(err_cnt_o), 64'd1);

    exp_err(2'd1, 1); send(8'hA6);
    exp_err(2'd0, 1); send(8'h12);
    exp_err(2'd0, 1); send(8'h34);
    idle(2);
    check("err_cnt_4", 64'(err_cnt_o), 64'd4);
    check("cmd_cnt_4", 64'(cmd_cnt_o), 64'd4);

    send(8'hA2);
    check("busy_hdr", 64'(busy_o), 64'd1);
    idle(7);
    check("busy_gap7", 64'(busy_o), 64'd1);
    send(8'h00);
    exp_cmd(3'd2, 16'h0001, 1); send(8'h01);
    send(8'hA2);
    exp_err(2'd2, 8);
    idle(8);
    check("busy_after_to", 64'(busy_o), 64'd0);
    exp_err(2'd0, 1); send(8'h00);
    exp_err(2'd0, 1); send(8'h01);
    idle(2);

    send(8'hA3); send(8'h00);
    exp_err(2'd3, 1); send(8'h00);
    send(8'hA3); send(8'hFF);
    exp_cmd(3'd3, 16'hFFFF, 1); send(8'hFF);
    idle(2);
    check("cmd_cnt_6", 64'(cmd_cnt_o), 64'd6);
    check("err_cnt_8", 64'(err_cnt_o), 64'd8);

    send(8'hA1); send(8'h00);
    byte_valid_i = 1'b0;
    check("busy_mid", 64'(busy_o), 64'd1);
    srst_i = 1'b0;
    @(negedge clk_i);
    check("busy_rst", 64'(busy_o), 64'd0);
    check("cnt_rst", {cmd_cnt_o, err_cnt_o}, 64'd0);
    srst_i = 1'b1;
    send(8'hA1); send(8'h00);
    exp_cmd(3'd1, 16'h0000, 1); send(8'h00);
    idle(3);
    check("cmd_cnt_post", 64'(cmd_cnt_o), 64'd1);
    check("err_cnt_post", 64'(err_cnt_o), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
